// File: rtl/seg7_scan_display.sv
// Multiplexed four-digit hex display driver for a common-anode seven-segment module.
// Latches a 32-bit word and scans one selected 16-bit half with leading-zero blanking.
module seg7_scan_display #(
  parameter int DIV_MAX = 100000,
  parameter int DIV_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        page,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

  logic [DIV_W-1:0] prescaler;
  logic [1:0]       scan_idx;
  logic [31:0]      shadow;
  logic             tick;
  logic [15:0]      half;
  logic [15:0]      upper;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       hex_seg;

  assign tick = (prescaler == DIV_LAST);

  // A digit is blanked when it and every more-significant nibble are zero;
  // digit 0 is always shown so a zero value still reads "0".
  always_comb begin
    half   = page ? shadow[31:16] : shadow[15:0];
    upper  = half >> {scan_idx, 2'b00};
    nibble = upper[3:0];
    blank  = blank_lz && (scan_idx != 2'd0) && (upper == 16'h0000);
  end

  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    hex_seg = 7'h7F;
    case (nibble)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

  // Outputs are registered from the pre-edge index and shadow, so a load
  // reaches the segments one edge after the shadow captures it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= 32'h0;
      prescaler  <= '0;
      scan_idx   <= 2'd0;
      AN         <= 4'b1111;
      SEGMENT    <= 8'hFF;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      if (load) shadow <= data_in;
      if (tick) begin
        prescaler <= '0;
        scan_idx  <= scan_idx + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      AN         <= ~(4'b0001 << scan_idx);
      digit_idx  <= scan_idx;
      SEGMENT    <= {~dp_in[scan_idx], blank ? 7'h7F : hex_seg};
      frame_done <= tick && (scan_idx == 2'd3);
    end
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Downstream display stage of the single-cycle CPU top. Latches a 32-bit word from the CPU datapath (PC, register or ALU result, chosen upstream by the switches). Time-multiplexes one 16-bit half of that word as four hex digits onto the board's common-anode 4-digit seven-segment display through AN/SEGMENT. Provides leading-zero blanking, per-digit decimal points and a frame-complete pulse.

Parameters:
DIV_MAX, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 1..2^DIV_W-1
DIV_W, 17, prescaler width; must satisfy 2^DIV_W > DIV_MAX-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
data_in  input  32  word to display
load  input  1  capture data_in into the shadow register on this edge
page  input  1  0 = show shadow[15:0], 1 = show shadow[31:16]
blank_lz  input  1  1 = enable leading-zero blanking
dp_in  input  4  decimal point request per digit, bit k = digit k, active-high
AN  output  4  digit enables, active-low, AN[0] = rightmost/least-significant digit
SEGMENT  output  8  active-low segments {dp,g,f,e,d,c,b,a}
digit_idx  output  2  digit currently driven on AN/SEGMENT
frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0

Behaviour:
- Reset (rst=1 at a clk edge): shadow=32'h0, prescaler=0, scan index=0, AN=4'b1111, SEGMENT=8'hFF, digit_idx=0, frame_done=0. Reset overrides load and ticks. Reset mid-scan restarts from digit 0 with a full slot.
- Prescaler:
  - Counts 0..DIV_MAX-1.
  - tick = (prescaler==DIV_MAX-1). On tick, prescaler<=0 and scan index<=index+1, wrapping 3->0.
  - DIV_MAX=1 gives a tick every cycle.
- frame_done: registered. It is 1 in the cycle after the tick that takes the index from 3 to 0, and 0 otherwise.
- Shadow: if load=1 (and rst=0), shadow<=data_in. Otherwise it holds. load=1 on consecutive cycles recaptures every cycle.
- Output register, updated every non-reset cycle from the current index i, current shadow, page, blank_lz and dp_in:
  - AN <= ~(4'b0001<<i).
  - digit_idx <= i.
  - nibble n = half[4i+3:4i], where half = page ? shadow[31:16] : shadow[15:0].
  - SEGMENT[6:0] <= hex(n), or 7'h7F if the digit is blanked.
  - SEGMENT[7] <= ~dp_in[i]. The decimal point is never blanked.
- Latency:
  - load to visible data: 2 cycles (shadow on edge N, output register on edge N+1).
  - page, blank_lz, dp_in changes: visible after 1 edge.
  - index change: visible 1 edge after the tick.
- Leading-zero blanking:
  - With blank_lz=1, digit k (k=1..3) is blanked when nibble k and every higher nibble of the selected half are 0.
  - Digit 0 is never blanked, so 0 shows as a single "0".
  - AN for a blanked digit stays asserted; only its segments go dark.
- hex() map, active-low {g..a}: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Simultaneous load and tick: both take effect. The output register on the following edge uses the new index and the new shadow. Shadow is not bypassed, so data_in never reaches SEGMENT in the same cycle.
- No combinational path exists from any input to AN, SEGMENT, digit_idx or frame_done.

Test Plan:
- DIV_MAX=4. Hold rst for 2 cycles -> AN=1111, SEGMENT=FF, frame_done=0. Release -> next edge AN=1110, SEGMENT=C0 (digit 0, value 0); AN changes every 4 cycles 1110->1101->1011->0111->1110; frame_done pulses once per 16 cycles, in the cycle after the 3->0 wrap.
- load with data_in=32'h1234ABCD, page=0, dp_in=0 -> 2 edges later digit 0 shows SEGMENT=A1 (d); over one frame digits 3..0 show 88,83,C6,A1 (A,b,C,d). Set page=1 -> 1 edge later digits 3..0 show F9,A4,B0,99 (1,2,3,4).
- data_in=32'h00000005, blank_lz=1, page=0 -> digits 3,2,1 show SEGMENT=FF; digit 0 shows 92. data_in=0 -> digit 0 shows C0 and the other digits show FF. blank_lz=0 -> digits 3..1 show C0.
- dp_in=4'b0100, blanked digit 2 -> SEGMENT=7F on digit 2; the decimal point remains lit while the segments are off.
- load asserted on the same edge as a tick, with DIV_MAX=1 -> no glitch value appears; SEGMENT follows the new data exactly 2 edges after load.
- Assert rst while scanning digit 2 -> next edge AN=1111; after release the scan resumes at digit 0 with a full 4-cycle slot and shadow=0.
